// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, sequencer states and small decode helpers.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Divide-class operation (DIV/DIVU/REM/REMU)
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Operand A treated as signed (MUL, MULH, MULHSU, DIV, REM)
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Operand B treated as signed (MUL, MULH, DIV, REM)
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared shift/add-subtract datapath.
//   mode_div : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i    : {hi, lo} accumulator (multiply: {partial, multiplier};
//              divide: {remainder, dividend/quotient})
//   opnd_i   : multiplicand magnitude or divisor magnitude
//   acc_o    : accumulator after this iteration (divide lsb left 0)
//   q_bit_o  : quotient bit produced by a divide step
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              mode_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_bit_o
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic            ge;

  always_comb begin
    hi      = acc_i[2*XLEN-1:XLEN];
    lo      = acc_i[XLEN-1:0];
    // Multiply: conditionally add, keep the carry as the new top bit
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    // Divide: bring down the next dividend bit and trial-subtract
    shifted = {hi, lo[XLEN-1]};
    ge      = (shifted >= {1'b0, opnd_i});

    acc_o   = {sum, lo[XLEN-1:1]};
    q_bit_o = 1'b0;
    if (mode_div) begin
      // A restored remainder is always below the divisor, so XLEN bits suffice
      acc_o   = {XLEN'(ge ? (shifted - {1'b0, opnd_i}) : shifted), lo[XLEN-2:0], 1'b0};
      q_bit_o = ge;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit with its sequencing FSM.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start, funct3     : request (sampled only in IDLE) and operation select
//   rs1_val, rs2_val  : operands, only used in the start cycle
//   flush             : abort any operation, return to IDLE
//   stall_req         : combinational pipeline hold request
//   busy, done        : state != IDLE, one-cycle result-valid pulse
//   result            : registered result, held until the next done
module muldiv_sequencer import muldiv_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned AW = 2 * XLEN;

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;       // product/quotient sign
  logic              a_neg_q, a_neg_d;   // dividend sign for the remainder
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_neg_c, b_neg_c;
  logic [XLEN-1:0]   a_abs_c, b_abs_c;
  logic [AW-1:0]     step_acc_c;
  logic              step_q_c;
  logic [AW-1:0]     prod_c;
  logic [XLEN-1:0]   quo_c, rem_c;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode_div (is_div(f3_q)),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc_c),
    .q_bit_o  (step_q_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      result_q <= result_d;
    end
  end

  // Next-state, datapath update and result fix-up
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    result_d = result_q;

    a_neg_c  = a_is_signed(funct3) && rs1_val[XLEN-1];
    b_neg_c  = b_is_signed(funct3) && rs2_val[XLEN-1];
    a_abs_c  = a_neg_c ? -rs1_val : rs1_val;
    b_abs_c  = b_neg_c ? -rs2_val : rs2_val;

    prod_c   = neg_q ? -acc_q : acc_q;
    quo_c    = acc_q[XLEN-1:0];
    rem_c    = acc_q[AW-1:XLEN];

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          f3_d    = funct3;
          cnt_d   = CNT_W'(XLEN - 1);
          neg_d   = a_neg_c ^ b_neg_c;
          a_neg_d = a_neg_c;
          state_d = CALC;
          if (is_div(funct3)) begin
            acc_d  = {{XLEN{1'b0}}, a_abs_c};
            opnd_d = b_abs_c;
            // funct3[1] selects remainder, funct3[0] selects unsigned
            if (rs2_val == '0) begin
              state_d  = DONE;
              result_d = funct3[1] ? rs1_val : '1;
            end else if (!funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                         (rs2_val == '1)) begin
              state_d  = DONE;
              result_d = funct3[1] ? '0 : rs1_val;
            end
          end else begin
            acc_d  = {{XLEN{1'b0}}, b_abs_c};
            opnd_d = a_abs_c;
          end
        end
      end
      CALC: begin
        acc_d = {step_acc_c[AW-1:1], step_acc_c[0] | step_q_c};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (is_div(f3_q)) begin
          result_d = f3_q[1] ? (a_neg_q ? -rem_c : rem_c) : (neg_q ? -quo_c : quo_c);
        end else begin
          result_d = (f3_q == F3_MUL) ? prod_c[XLEN-1:0] : prod_c[AW-1:XLEN];
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including the last CALC iteration
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  assign stall_req = ((state_q == IDLE) && start && !flush) ||
                     (state_q == CALC) || (state_q == FIX);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus multi-cycle
// sequences for flush, ignored start, start+flush and async reset.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      funct3 = 3'b000;
  logic [XLEN-1:0] rs1_val = '0;
  logic [XLEN-1:0] rs2_val = '0;
  logic            flush = 1'b0;
  logic            stall_req, busy, done;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_err = 0;
  int cyc, stl;
  logic [31:0] last_res = 32'd0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[$];

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .funct3    (funct3),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request for one cycle, then scramble the operand inputs
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f3; rs1_val = a; rs2_val = b; start = 1'b1;
    #1;
    stl = (stall_req === 1'b1) ? 1 : 0;
    @(negedge clk);
    start = 1'b0;
    funct3 = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom;
    #1;
    cyc = 1;
  endtask

  // Wait for done with a cycle budget; optionally pulse start at cycle inject_at
  task automatic wait_done(input int inject_at);
    while (done !== 1'b1 && cyc < 80) begin
      if (stall_req === 1'b1) stl++;
      if (cyc == inject_at) begin
        start = 1'b1; funct3 = F3_DIVU; rs1_val = 32'd100; rs2_val = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit special,
                        input int inject_at);
    int exp_lat;
    exp_lat = special ? 1 : XLEN + 2;
    issue(f3, a, b);
    wait_done(inject_at);
    check({name, " latency"}, 32'(cyc), 32'(exp_lat));
    check({name, " stall cycles"}, 32'(stl), 32'(exp_lat));
    check({name, " result"}, result, exp);
    check({name, " stall in done"}, {31'd0, stall_req}, 32'd0);
    @(negedge clk); #1;
    check({name, " idle after"}, {30'd0, busy, done}, 32'd0);
    last_res = exp;
  endtask

  initial begin
    vecs.push_back(vec_t'{"mul 7*-3",       F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back(vec_t'{"mul 3*4",        F3_MUL,    32'd3,          32'd4,         32'd12,        1'b0});
    vecs.push_back(vec_t'{"mul min*min",    F3_MUL,    32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back(vec_t'{"mulh min*min",   F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0});
    vecs.push_back(vec_t'{"mulh max*max",   F3_MULH,   32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0});
    vecs.push_back(vec_t'{"mulhu min*min",  F3_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0});
    vecs.push_back(vec_t'{"mulhu ones",     F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
    vecs.push_back(vec_t'{"mulhsu -1*2",    F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0});
    vecs.push_back(vec_t'{"div -7/2",       F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0});
    vecs.push_back(vec_t'{"rem -7/2",       F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0});
    vecs.push_back(vec_t'{"div 7/-2",       F3_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back(vec_t'{"rem 7/-2",       F3_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0});
    vecs.push_back(vec_t'{"div min/1",      F3_DIV,    32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0});
    vecs.push_back(vec_t'{"divu 100/7",     F3_DIVU,   32'd100,        32'd7,         32'd14,        1'b0});
    vecs.push_back(vec_t'{"remu 100/7",     F3_REMU,   32'd100,        32'd7,         32'd2,         1'b0});
    vecs.push_back(vec_t'{"divu max/1",     F3_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b0});
    vecs.push_back(vec_t'{"remu 5/max",     F3_REMU,   32'd5,          32'hFFFF_FFFF, 32'd5,         1'b0});
    vecs.push_back(vec_t'{"divu 5/0",       F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1});
    vecs.push_back(vec_t'{"div 5/0",        F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1});
    vecs.push_back(vec_t'{"rem 5/0",        F3_REM,    32'd5,          32'd0,         32'd5,         1'b1});
    vecs.push_back(vec_t'{"remu 9/0",       F3_REMU,   32'd9,          32'd0,         32'd9,         1'b1});
    vecs.push_back(vec_t'{"div ovf",        F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vecs.push_back(vec_t'{"rem ovf",        F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1});
    vecs.push_back(vec_t'{"divu 100/7 b",   F3_DIVU,   32'd100,        32'd7,         32'd14,        1'b0});

    // Reset state
    #12;
    check("reset busy/done/stall", {29'd0, busy, done, stall_req}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].special, -1);

    // Flush ten cycles into a divide: no done, result untouched
    begin
      int n_done;
      issue(F3_DIV, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush busy", {31'd0, busy}, 32'd0);
      check("flush stall", {31'd0, stall_req}, 32'd0);
      n_done = 0;
      for (int k = 0; k < 40; k++) begin
        if (done === 1'b1) n_done++;
        @(negedge clk); #1;
      end
      check("flush no done", 32'(n_done), 32'd0);
      check("flush result held", result, last_res);
    end

    // start pulsed mid-CALC is ignored and not queued
    run_op("mul ignore start", F3_MUL, 32'd5, 32'd6, 32'd30, 1'b0, 5);
    begin
      int n_busy;
      n_busy = 0;
      for (int k = 0; k < 5; k++) begin
        if (busy !== 1'b0) n_busy++;
        @(negedge clk); #1;
      end
      check("no queued op", 32'(n_busy), 32'd0);
    end

    // start with flush in the same cycle
    @(negedge clk);
    funct3 = F3_MUL; rs1_val = 32'd2; rs2_val = 32'd2; start = 1'b1; flush = 1'b1;
    #1;
    check("start+flush stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("start+flush busy", {30'd0, busy, done}, 32'd0);
    check("start+flush result", result, 32'd30);

    // Asynchronous reset mid-CALC
    issue(F3_MUL, 32'd9, 32'd9);
    repeat (10) @(negedge clk);
    #2;
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst busy/done/stall", {29'd0, busy, done, stall_req}, 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul 3*4 after reset", F3_MUL, 32'd3, 32'd4, 32'd12, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
